// File: rtl/audio_mix_pkg.sv
// Shared types and helpers for the stereo mixer / sigma-delta DAC.
// Holds the FSM state encoding, pan codes, the accumulator-width rule and the clamp helper.
package audio_mix_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        CLAMP = 2'd2
    } mix_state_t;

    localparam logic [1:0] PAN_BOTH = 2'b00;
    localparam logic [1:0] PAN_L    = 2'b01;
    localparam logic [1:0] PAN_R    = 2'b10;

    localparam int CLAMP_W = 64;

    typedef struct packed {
        logic               clip;
        logic [CLAMP_W-1:0] value;
    } clamp_t;

    // Headroom for a 7-bit gain shift and the sum of num_ch channels, plus a sign guard bit.
    function automatic int acc_width(input int in_w, input int num_ch);
        return in_w + 7 + $clog2(num_ch) + 1;
    endfunction

    // Saturate to a signed out_w range, then flip the sign bit to get offset binary.
    // Only the low out_w bits of the returned value are meaningful.
    function automatic clamp_t clamp_offset(input logic signed [CLAMP_W-1:0] acc, input int out_w);
        clamp_t                    res;
        logic signed [CLAMP_W-1:0] half;
        logic signed [CLAMP_W-1:0] hi;
        logic signed [CLAMP_W-1:0] lo;
        half      = 64'sd1 <<< (out_w - 1);
        hi        = half - 64'sd1;
        lo        = -half;
        res.clip  = 1'b0;
        res.value = acc;
        if (acc > hi) begin
            res.clip  = 1'b1;
            res.value = hi;
        end else if (acc < lo) begin
            res.clip  = 1'b1;
            res.value = lo;
        end
        res.value = res.value ^ half;
        return res;
    endfunction

endpackage

// File: rtl/audio_dsm_1bit.sv
// Leaky first-order sigma-delta modulator: offset-binary sample in, 1-bit stream out.
module audio_dsm_1bit #(
    parameter int OUT_W      = 16,
    parameter int DSM_W      = 32,
    parameter int LEAK_SHIFT = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OUT_W-1:0] mix,
    output logic             aud
);

    logic [DSM_W-1:0] acc_reg;
    logic [DSM_W-1:0] acc_next;
    logic             bit_reg;
    logic             bit_next;

    // acc tracks the low-passed output density scaled to 2^DSM_W; the loop drives it toward mix.
    always_comb begin
        bit_next = (acc_reg[DSM_W-1 -: OUT_W] < mix);
        acc_next = acc_reg - (acc_reg >> LEAK_SHIFT)
                 + (DSM_W'(bit_reg) << (DSM_W - LEAK_SHIFT));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_reg <= '0;
            bit_reg <= 1'b0;
        end else begin
            acc_reg <= acc_next;
            bit_reg <= bit_next;
        end
    end

    assign aud = bit_reg;

endmodule

// File: rtl/audio_mixer_dac.sv
// Stereo mixer for NUM_CH signed sources with per-channel enable, gain and pan,
// feeding one sigma-delta modulator per side.
module audio_mixer_dac
    import audio_mix_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int IN_W       = 16,
    parameter int OUT_W      = 16,
    parameter int DSM_W      = 32,
    parameter int LEAK_SHIFT = 7
) (
    input  logic                   clk_vga,
    input  logic                   reset_wire,
    input  logic                   sample_stb,
    input  logic [NUM_CH*IN_W-1:0] ch_data,
    input  logic [NUM_CH-1:0]      ch_en,
    input  logic [NUM_CH*3-1:0]    ch_gain,
    input  logic [NUM_CH*2-1:0]    ch_pan,
    input  logic                   clip_clr,
    output logic                   busy,
    output logic                   mix_valid,
    output logic [OUT_W-1:0]       mix_l,
    output logic [OUT_W-1:0]       mix_r,
    output logic                   clip_l,
    output logic                   clip_r,
    output logic                   overrun,
    output logic                   aud_l,
    output logic                   aud_r
);

    localparam int ACC_W = acc_width(IN_W, NUM_CH);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
    localparam logic [OUT_W-1:0] SILENCE  = OUT_W'(1) << (OUT_W - 1);

    logic signed [IN_W-1:0] data_in [NUM_CH];
    logic [2:0]             gain_in [NUM_CH];
    logic [1:0]             pan_in  [NUM_CH];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign data_in[gi] = ch_data[gi*IN_W +: IN_W];
            assign gain_in[gi] = ch_gain[gi*3 +: 3];
            assign pan_in[gi]  = ch_pan[gi*2 +: 2];
        end
    endgenerate

    mix_state_t             state_reg, state_next;
    logic signed [IN_W-1:0] data_snap_reg [NUM_CH];
    logic [2:0]             gain_snap_reg [NUM_CH];
    logic [1:0]             pan_snap_reg  [NUM_CH];
    logic [NUM_CH-1:0]      en_snap_reg;
    logic [IDX_W-1:0]       ch_idx_reg;
    logic signed [ACC_W-1:0] acc_l_reg, acc_r_reg;
    logic                   mix_valid_reg, clip_l_reg, clip_r_reg, overrun_reg;
    logic [OUT_W-1:0]       mix_l_reg, mix_r_reg;
    logic                   load, accum_en, finish;
    logic signed [ACC_W-1:0] term;
    clamp_t                 clamp_l, clamp_r;
    logic                   clamp_unused;

    always_ff @(posedge clk_vga or posedge reset_wire) begin
        if (reset_wire) state_reg <= IDLE;
        else            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        accum_en   = 1'b0;
        finish     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (sample_stb) begin
                    load       = 1'b1;
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                accum_en = 1'b1;
                if (ch_idx_reg == LAST_IDX) state_next = CLAMP;
            end
            CLAMP: begin
                finish     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Sign-extend before shifting so the gain never drops significant bits.
    assign term    = ACC_W'(data_snap_reg[ch_idx_reg]) <<< gain_snap_reg[ch_idx_reg];
    assign clamp_l = clamp_offset(CLAMP_W'(acc_l_reg), OUT_W);
    assign clamp_r = clamp_offset(CLAMP_W'(acc_r_reg), OUT_W);
    assign clamp_unused = ^{clamp_l.value[CLAMP_W-1:OUT_W], clamp_r.value[CLAMP_W-1:OUT_W]};

    always_ff @(posedge clk_vga or posedge reset_wire) begin
        if (reset_wire) begin
            for (int k = 0; k < NUM_CH; k++) begin
                data_snap_reg[k] <= '0;
                gain_snap_reg[k] <= '0;
                pan_snap_reg[k]  <= PAN_BOTH;
            end
            en_snap_reg   <= '0;
            ch_idx_reg    <= '0;
            acc_l_reg     <= '0;
            acc_r_reg     <= '0;
            mix_valid_reg <= 1'b0;
            mix_l_reg     <= SILENCE;
            mix_r_reg     <= SILENCE;
            clip_l_reg    <= 1'b0;
            clip_r_reg    <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            mix_valid_reg <= finish;
            if (load) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    data_snap_reg[k] <= data_in[k];
                    gain_snap_reg[k] <= gain_in[k];
                    pan_snap_reg[k]  <= pan_in[k];
                end
                en_snap_reg <= ch_en;
                ch_idx_reg  <= '0;
                acc_l_reg   <= '0;
                acc_r_reg   <= '0;
            end
            if (accum_en) begin
                if (ch_idx_reg != LAST_IDX) ch_idx_reg <= ch_idx_reg + 1'b1;
                if (en_snap_reg[ch_idx_reg]) begin
                    if (pan_snap_reg[ch_idx_reg] != PAN_R) acc_l_reg <= acc_l_reg + term;
                    if (pan_snap_reg[ch_idx_reg] != PAN_L) acc_r_reg <= acc_r_reg + term;
                end
            end
            if (finish) begin
                mix_l_reg <= clamp_l.value[OUT_W-1:0];
                mix_r_reg <= clamp_r.value[OUT_W-1:0];
            end
            // Set events take priority over a same-cycle clear.
            if (finish && clamp_l.clip) clip_l_reg <= 1'b1;
            else if (clip_clr)          clip_l_reg <= 1'b0;
            if (finish && clamp_r.clip) clip_r_reg <= 1'b1;
            else if (clip_clr)          clip_r_reg <= 1'b0;
            if (sample_stb && state_reg != IDLE) overrun_reg <= 1'b1;
            else if (clip_clr)                   overrun_reg <= 1'b0;
        end
    end

    assign busy      = (state_reg != IDLE);
    assign mix_valid = mix_valid_reg;
    assign mix_l     = mix_l_reg;
    assign mix_r     = mix_r_reg;
    assign clip_l    = clip_l_reg;
    assign clip_r    = clip_r_reg;
    assign overrun   = overrun_reg;

    audio_dsm_1bit #(.OUT_W(OUT_W), .DSM_W(DSM_W), .LEAK_SHIFT(LEAK_SHIFT)) u_dsm_l (
        .clk   (clk_vga),
        .reset (reset_wire),
        .mix   (mix_l_reg),
        .aud   (aud_l)
    );

    audio_dsm_1bit #(.OUT_W(OUT_W), .DSM_W(DSM_W), .LEAK_SHIFT(LEAK_SHIFT)) u_dsm_r (
        .clk   (clk_vga),
        .reset (reset_wire),
        .mix   (mix_r_reg),
        .aud   (aud_r)
    );

endmodule

// File: doc/audio_mixer_dac.md
Name: audio_mixer_dac

Overview:
- Parametrised stereo mixer and 1-bit sigma-delta DAC for the PCXT sound sources (OPL2, Tandy PSG, PC speaker, future sources).
- Mixes NUM_CH signed channels with per-channel enable, gain shift and pan into left and right buses. Each bus is clamped to OUT_W bits, converted to offset binary, and fed to a leaky first-order sigma-delta modulator driving AUD_L and AUD_R.
- Sits at the top level beside CHIPSET and replaces the fixed-width inline mixer and modulator.

Parameters:
- NUM_CH, 4, number of input channels (1..8)
- IN_W, 16, signed sample width per channel
- OUT_W, 16, mixed sample width and modulator compare width
- DSM_W, 32, modulator accumulator width (must be greater than OUT_W + LEAK_SHIFT)
- LEAK_SHIFT, 7, modulator leak shift; feedback weight is 2^(DSM_W-LEAK_SHIFT)

Ports:
- clk_vga  in  1  system audio clock (28.636 MHz)
- reset_wire  in  1  reset, asynchronous, active-high
- sample_stb  in  1  one-cycle pulse that starts a mix pass
- ch_data  in  NUM_CH*IN_W  signed samples, channel k at [k*IN_W +: IN_W]
- ch_en  in  NUM_CH  channel enable; 0 = channel contributes 0
- ch_gain  in  NUM_CH*3  left-shift amount 0..7 per channel
- ch_pan  in  NUM_CH*2  per channel: 00 = both, 01 = left only, 10 = right only, 11 = both
- clip_clr  in  1  clears sticky clip and overrun flags
- busy  out  1  mix pass in progress
- mix_valid  out  1  one-cycle pulse when mix_l and mix_r update
- mix_l, mix_r  out  OUT_W  clamped mix, offset binary
- clip_l, clip_r  out  1  sticky saturation flags
- overrun  out  1  sticky flag: sample_stb arrived while busy
- aud_l, aud_r  out  1  modulator bitstreams

Behaviour:
- Reset (asynchronous, any time including mid-pass):
  - FSM goes to IDLE.
  - busy, mix_valid, clip_*, overrun, aud_* = 0.
  - mix_l and mix_r = 2^(OUT_W-1) (silence).
  - Modulator accumulators = 0.
  - Accumulation stops immediately.
- FSM states IDLE, ACCUM, CLAMP:
  - IDLE: on sample_stb, snapshot ch_data, ch_en, ch_gain and ch_pan into registers; zero acc_l and acc_r; set ch_idx = 0; go to ACCUM with busy = 1.
  - ACCUM: one channel per cycle. term = sign-extend(snapshot[ch_idx]) <<< gain. If enabled, add term to acc_l when pan != 10, and to acc_r when pan != 01. When ch_idx == NUM_CH-1, go to CLAMP; otherwise increment ch_idx.
  - CLAMP: saturate each accumulator to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. Invert the MSB to form offset binary and register the result into mix_l/mix_r. Pulse mix_valid, drop busy, return to IDLE.
  - If saturation occurred on a side, set clip_l or clip_r.
- Latency: mix_valid is high exactly NUM_CH+2 cycles after the sample_stb cycle.
- Maximum sustained strobe rate: one per NUM_CH+2 cycles.
- Accumulator width: ACC_W = IN_W + 7 + clog2(NUM_CH) + 1. No internal overflow is possible.
- sample_stb while busy (including the CLAMP cycle): ignored and sets overrun. The pass in progress is unaffected.
- clip_clr clears clip_l, clip_r and overrun. If a set event occurs in the same cycle, the set wins.
- Inputs may change freely during a pass; only the snapshot is used.
- Modulator, one per side, runs every clk_vga cycle independent of the FSM:
  - bit_n = (acc[DSM_W-1 -: OUT_W] < mix).
  - acc <= acc - (acc >> LEAK_SHIFT) + (bit_r << (DSM_W-LEAK_SHIFT)), unsigned, with bit_r the registered bit.
  - aud = bit_r.
  - A new mix value takes effect the cycle after mix_valid.

Decomposition:
- Package audio_mix_pkg holds:
  - FSM state enum (IDLE, ACCUM, CLAMP)
  - pan encodings (PAN_BOTH, PAN_L, PAN_R)
  - an acc_width(in_w, num_ch) function
  - a clamp-to-offset-binary function
- Sub-module audio_dsm_1bit (parameters OUT_W, DSM_W, LEAK_SHIFT; ports clk, reset, mix, aud), instantiated twice.

Test Plan:
- ch0 = +1000, gain 0, pan 00, others disabled; pulse sample_stb → mix_valid exactly 6 cycles later; mix_l = mix_r = 0x83E8; no clip.
- All 4 channels 0x7FFF, gain 1 → mix_l = mix_r = 0xFFFF and clip_l = clip_r = 1. Repeat with 0x8000 → 0x0000. Then clip_clr → flags 0.
- ch0 = +0x1000 pan 01, ch1 = -0x0800 pan 10 → mix_l = 0x9000, mix_r = 0x7800.
- sample_stb at cycles 0 and 3 → a single mix_valid at cycle 6 and overrun = 1. Strobe at cycle 6 (IDLE) → accepted.
- Hold mix_l = 0xC000 for 2^16 cycles after settling → aud_l ones density 0.75 ±0.01. Hold 0x8000 → 0.50 ±0.01.
- Assert reset_wire during ACCUM → busy = 0, mix_l = mix_r = 0x8000, no mix_valid. After release, the next strobe completes normally.
